// File: rtl/id_stage_pipe.sv
// MIPS instruction-decode stage: control decode, register file with optional write-through,
// immediate extension, load-use hazard detection and the ID/EX pipeline register.
module id_stage_pipe #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NREG   = 32,
    parameter bit          BYPASS = 1'b1,
    localparam int unsigned AW    = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    input  logic [31:0]     if_instr,
    input  logic [XLEN-1:0] if_pc,
    output logic            id_ready,
    input  logic            flush,
    input  logic            ex_ready,
    input  logic            wb_en,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs_data,
    output logic [XLEN-1:0] ex_rt_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [XLEN-1:0] ex_jtarget,
    output logic [AW-1:0]   ex_dest,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_mem_to_reg,
    output logic            ex_alu_src,
    output logic            ex_branch,
    output logic            ex_jump,
    output logic            ex_illegal,
    output logic [3:0]      ex_alu_ctrl
);

    logic [XLEN-1:0] regs [NREG];
    logic [5:0]      opcode, funct;
    logic [AW-1:0]   rs_idx, rt_idx, rd_idx;
    logic [XLEN-1:0] rs_val, rt_val, imm_val, pc4, jtarget;

    assign opcode = if_instr[31:26];
    assign funct  = if_instr[5:0];
    assign rs_idx = if_instr[21 +: AW];
    assign rt_idx = if_instr[16 +: AW];
    assign rd_idx = if_instr[11 +: AW];
    assign pc4     = if_pc + XLEN'(4);
    assign jtarget = {pc4[XLEN-1:28], if_instr[25:0], 2'b00};

    logic unused_bits;
    assign unused_bits = ^{if_instr[25:6], pc4[27:0]};

    // Register 0 is hardwired; write-through only when BYPASS is set.
    always_comb begin
        if (rs_idx == '0)                                 rs_val = '0;
        else if (BYPASS && wb_en && (wb_addr == rs_idx)) rs_val = wb_data;
        else                                              rs_val = regs[rs_idx];
        if (rt_idx == '0)                                 rt_val = '0;
        else if (BYPASS && wb_en && (wb_addr == rt_idx)) rt_val = wb_data;
        else                                              rt_val = regs[rt_idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (wb_en && (wb_addr != '0)) begin
            regs[wb_addr] <= wb_data;
        end
    end

    logic       dec_reg_write, dec_mem_read, dec_mem_write, dec_mem_to_reg, dec_alu_src;
    logic       dec_branch, dec_jump, dec_illegal, dec_reg_dst, dec_zext, rs_used, rt_used;
    logic [3:0] dec_alu_ctrl;

    always_comb begin
        dec_reg_write  = 1'b0;
        dec_mem_read   = 1'b0;
        dec_mem_write  = 1'b0;
        dec_mem_to_reg = 1'b0;
        dec_alu_src    = 1'b0;
        dec_branch     = 1'b0;
        dec_jump       = 1'b0;
        dec_illegal    = 1'b0;
        dec_reg_dst    = 1'b0;
        dec_zext       = 1'b0;
        dec_alu_ctrl   = 4'b0000;
        rs_used        = 1'b1;
        rt_used        = 1'b0;
        case (opcode)
            6'b000000: begin
                dec_reg_dst   = 1'b1;
                dec_reg_write = 1'b1;
                rt_used       = 1'b1;
                case (funct)
                    6'b100000: dec_alu_ctrl = 4'b0010;
                    6'b100010: dec_alu_ctrl = 4'b0110;
                    6'b100100: dec_alu_ctrl = 4'b0000;
                    6'b100101: dec_alu_ctrl = 4'b0001;
                    6'b101010: dec_alu_ctrl = 4'b0111;
                    6'b100111: dec_alu_ctrl = 4'b1100;
                    default: begin
                        dec_illegal   = 1'b1;
                        dec_reg_write = 1'b0;
                    end
                endcase
            end
            6'b100011: begin
                dec_alu_src    = 1'b1;
                dec_mem_read   = 1'b1;
                dec_mem_to_reg = 1'b1;
                dec_reg_write  = 1'b1;
                dec_alu_ctrl   = 4'b0010;
            end
            6'b101011: begin
                dec_alu_src   = 1'b1;
                dec_mem_write = 1'b1;
                dec_alu_ctrl  = 4'b0010;
                rt_used       = 1'b1;
            end
            6'b000100: begin
                dec_branch   = 1'b1;
                dec_alu_ctrl = 4'b0110;
                rt_used      = 1'b1;
            end
            6'b001000: begin
                dec_alu_src = 1'b1; dec_reg_write = 1'b1; dec_alu_ctrl = 4'b0010;
            end
            6'b001100: begin
                dec_alu_src = 1'b1; dec_reg_write = 1'b1; dec_alu_ctrl = 4'b0000;
                dec_zext = 1'b1;
            end
            6'b001101: begin
                dec_alu_src = 1'b1; dec_reg_write = 1'b1; dec_alu_ctrl = 4'b0001;
                dec_zext = 1'b1;
            end
            6'b001010: begin
                dec_alu_src = 1'b1; dec_reg_write = 1'b1; dec_alu_ctrl = 4'b0111;
            end
            6'b000010: begin
                dec_jump     = 1'b1;
                dec_alu_ctrl = 4'b0010;
                rs_used      = 1'b0;
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    assign imm_val = dec_zext ? {{(XLEN-16){1'b0}}, if_instr[15:0]}
                              : {{(XLEN-16){if_instr[15]}}, if_instr[15:0]};

    logic stall, hazard;
    assign stall  = ex_valid && !ex_ready;
    assign hazard = ex_valid && ex_mem_read && (ex_dest != '0) &&
                    ((rs_used && (ex_dest == rs_idx)) || (rt_used && (ex_dest == rt_idx)));
    assign id_ready = !rst && !flush && !stall && !hazard;

    // A flush overrides a stall; otherwise a stall holds everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid <= 1'b0;  ex_pc <= '0;  ex_rs_data <= '0;  ex_rt_data <= '0;
            ex_imm <= '0;  ex_jtarget <= '0;  ex_dest <= '0;
            ex_reg_write <= 1'b0;  ex_mem_read <= 1'b0;  ex_mem_write <= 1'b0;
            ex_mem_to_reg <= 1'b0;  ex_alu_src <= 1'b0;  ex_branch <= 1'b0;
            ex_jump <= 1'b0;  ex_illegal <= 1'b0;  ex_alu_ctrl <= 4'b0000;
        end else if (flush || !stall) begin
            if (flush || hazard || !if_valid) begin
                ex_valid <= 1'b0;
                ex_reg_write <= 1'b0;  ex_mem_read <= 1'b0;  ex_mem_write <= 1'b0;
                ex_mem_to_reg <= 1'b0;  ex_alu_src <= 1'b0;  ex_branch <= 1'b0;
                ex_jump <= 1'b0;  ex_illegal <= 1'b0;  ex_alu_ctrl <= 4'b0000;
            end else begin
                ex_valid      <= 1'b1;
                ex_pc         <= if_pc;
                ex_rs_data    <= rs_val;
                ex_rt_data    <= rt_val;
                ex_imm        <= imm_val;
                ex_jtarget    <= jtarget;
                ex_dest       <= dec_reg_dst ? rd_idx : rt_idx;
                ex_reg_write  <= dec_reg_write;
                ex_mem_read   <= dec_mem_read;
                ex_mem_write  <= dec_mem_write;
                ex_mem_to_reg <= dec_mem_to_reg;
                ex_alu_src    <= dec_alu_src;
                ex_branch     <= dec_branch;
                ex_jump       <= dec_jump;
                ex_illegal    <= dec_illegal;
                ex_alu_ctrl   <= dec_alu_ctrl;
            end
        end
    end

endmodule
